// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with parallel load, wrap/saturate ends,
// terminal-count flag, wrap pulse and a saturating wrap-event counter.
module modn_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 12,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_stat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err,
    output logic [7:0]       wrap_cnt
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $fatal(1, "modn_updown_counter: MODULUS out of range 2..2**WIDTH");
        end
    endgenerate

    // One extra bit so MODULUS = 2**WIDTH is representable for the range test.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

    logic             in_range;
    logic             wrap_ev;
    logic [WIDTH-1:0] count_nxt;

    assign in_range = ({1'b0, data_in} < MOD_EXT);
    assign tc       = mode ? (count == TOP) : (count == '0);
    assign wrap_ev  = !load && en && tc && (SATURATE == 0);

    always_comb begin
        count_nxt = count;
        if (load) begin
            if (in_range) begin
                count_nxt = data_in;
            end
        end else if (en) begin
            if (tc) begin
                if (SATURATE == 0) begin
                    count_nxt = mode ? '0 : TOP;
                end
            end else begin
                count_nxt = mode ? count + 1'b1 : count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
            wrap_cnt <= 8'd0;
        end else begin
            count    <= count_nxt;
            wrap     <= wrap_ev;
            load_err <= load && !in_range;
            if (clr_stat) begin
                wrap_cnt <= 8'd0;
            end else if (wrap_ev && wrap_cnt != 8'hFF) begin
                wrap_cnt <= wrap_cnt + 8'd1;
            end
        end
    end

endmodule
